// File: rtl/mux2_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux2_rr_arbiter
// Purpose  : Two-input packet arbiter. Round-robin between idle requesters,
//            packets are never interleaved, and a registered grant steers a
//            two-input mux onto a single valid/ready output stream.
// Revision : 1.0  initial release
// ============================================================================
module mux2_rr_arbiter #(
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in0_val,
    output logic             in0_rdy,
    input  logic [NBITS-1:0] in0_data,
    input  logic             in0_last,
    input  logic             in1_val,
    output logic             in1_rdy,
    input  logic [NBITS-1:0] in1_data,
    input  logic             in1_last,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [NBITS-1:0] out_data,
    output logic             out_last,
    output logic             sel
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_GNT0 = 2'd1;
    localparam logic [1:0] c_GNT1 = 2'd2;

    logic [1:0] r_fsm;
    logic       r_last_gnt;
    logic       r_sel;

    logic [1:0] w_fsm_next;
    logic       w_last_gnt_next;
    logic       w_sel_next;
    logic       w_xfer0;
    logic       w_xfer1;

    // A beat moves only when the owning requester is valid and the consumer is ready.
    assign w_xfer0 = in0_val & out_rdy;
    assign w_xfer1 = in1_val & out_rdy;

    // State register: grant FSM, round-robin history and the registered mux select.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fsm      <= c_IDLE;
            r_last_gnt <= 1'b1;
            r_sel      <= 1'b0;
        end else begin
            r_fsm      <= w_fsm_next;
            r_last_gnt <= w_last_gnt_next;
            r_sel      <= w_sel_next;
        end
    end

    // Next-state logic: arbitrate from IDLE, hold the grant until the last beat,
    // and hand straight over to a waiting requester with no bubble.
    always_comb begin
        w_fsm_next      = r_fsm;
        w_last_gnt_next = r_last_gnt;
        case (r_fsm)
            c_IDLE: begin
                if (in0_val && in1_val) begin
                    w_fsm_next = r_last_gnt ? c_GNT0 : c_GNT1;
                end else if (in0_val) begin
                    w_fsm_next = c_GNT0;
                end else if (in1_val) begin
                    w_fsm_next = c_GNT1;
                end
            end
            c_GNT0: begin
                if (w_xfer0 && in0_last) begin
                    w_last_gnt_next = 1'b0;
                    w_fsm_next      = in1_val ? c_GNT1 : c_IDLE;
                end
            end
            c_GNT1: begin
                if (w_xfer1 && in1_last) begin
                    w_last_gnt_next = 1'b1;
                    w_fsm_next      = in0_val ? c_GNT0 : c_IDLE;
                end
            end
            default: begin
                w_fsm_next = c_IDLE;
            end
        endcase

        // Select follows the grant; while idle it keeps the last owner.
        w_sel_next = r_sel;
        if (w_fsm_next == c_GNT0) begin
            w_sel_next = 1'b0;
        end else if (w_fsm_next == c_GNT1) begin
            w_sel_next = 1'b1;
        end
    end

    // Output logic: only the granted requester sees ready, which is just out_rdy,
    // so ready never depends on that requester's own valid.
    always_comb begin
        out_val = 1'b0;
        in0_rdy = 1'b0;
        in1_rdy = 1'b0;
        case (r_fsm)
            c_GNT0: begin
                out_val = in0_val;
                in0_rdy = out_rdy;
            end
            c_GNT1: begin
                out_val = in1_val;
                in1_rdy = out_rdy;
            end
            default: begin
                out_val = 1'b0;
            end
        endcase
    end

    assign sel      = r_sel;
    assign out_data = r_sel ? in1_data : in0_data;
    assign out_last = r_sel ? in1_last : in0_last;

endmodule
`default_nettype wire

// File: tb/tb_mux2_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux2_rr_arbiter
// Purpose  : Directed self-checking bench for mux2_rr_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_mux2_rr_arbiter;

    localparam int NBITS = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             in0_val, in0_rdy, in0_last;
    logic             in1_val, in1_rdy, in1_last;
    logic [NBITS-1:0] in0_data, in1_data, out_data;
    logic             out_val, out_rdy, out_last, sel;

    int checks = 0;
    int errors = 0;
    int xfer_cnt = 0;
    int xfer_base;

    mux2_rr_arbiter #(.NBITS(NBITS)) dut (
        .clk      (clk),
        .reset    (reset),
        .in0_val  (in0_val),
        .in0_rdy  (in0_rdy),
        .in0_data (in0_data),
        .in0_last (in0_last),
        .in1_val  (in1_val),
        .in1_rdy  (in1_rdy),
        .in1_data (in1_data),
        .in1_last (in1_last),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .out_last (out_last),
        .sel      (sel)
    );

    always #5 clk = ~clk;

    // Count accepted output beats.
    always @(posedge clk) begin
        if (out_val && out_rdy) xfer_cnt <= xfer_cnt + 1;
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in0_val = 0; in0_last = 0; in0_data = '0;
        in1_val = 0; in1_last = 0; in1_data = '0;
        out_rdy = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
        #1;
    endtask

    initial begin
        reset = 0;
        idle_inputs();
        #2;

        // ---------------- Test 1: single requester, single beat ----------------
        do_reset();
        check_value("rst_out_val", out_val, 0);
        check_value("rst_in0_rdy", in0_rdy, 0);
        check_value("rst_in1_rdy", in1_rdy, 0);
        check_value("rst_sel",     sel, 0);
        in0_val = 1; in0_last = 1; in0_data = 8'hA5;
        #1;
        check_value("t1_bubble_val", out_val, 0);
        check_value("t1_bubble_rdy", in0_rdy, 0);
        tick();
        check_value("t1_sel",      sel, 0);
        check_value("t1_out_val",  out_val, 1);
        check_value("t1_out_data", out_data, 8'hA5);
        check_value("t1_out_last", out_last, 1);
        check_value("t1_in0_rdy",  in0_rdy, 1);
        check_value("t1_in1_rdy",  in1_rdy, 0);
        tick();
        in0_val = 0;
        #1;
        check_value("t1_idle_val", out_val, 0);
        check_value("t1_idle_rdy", in0_rdy, 0);
        tick();
        check_value("t1_idle_hold", out_val, 0);

        // ---------------- Test 2: both requesting, alternating ----------------
        do_reset();
        in0_val = 1; in0_last = 1; in0_data = 8'h11;
        in1_val = 1; in1_last = 1; in1_data = 8'h22;
        #1;
        check_value("t2_bubble", out_val, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_value("t2_val",  out_val, 1);
            check_value("t2_sel",  sel, (i % 2));
            check_value("t2_data", out_data, (i % 2) ? 8'h22 : 8'h11);
            check_value("t2_rdy0", in0_rdy, (i % 2) ? 0 : 1);
            check_value("t2_rdy1", in1_rdy, (i % 2) ? 1 : 0);
        end

        // ---------------- Test 3: packet lock ----------------
        do_reset();
        in0_val = 1; in0_last = 0; in0_data = 8'h01;
        tick();
        in1_val = 1; in1_last = 1; in1_data = 8'h44;
        #1;
        check_value("t3_b1_data", out_data, 8'h01);
        check_value("t3_b1_rdy1", in1_rdy, 0);
        tick();
        in0_data = 8'h02;
        #1;
        check_value("t3_b2_data", out_data, 8'h02);
        check_value("t3_b2_rdy1", in1_rdy, 0);
        check_value("t3_b2_sel",  sel, 0);
        tick();
        in0_data = 8'h03; in0_last = 1;
        #1;
        check_value("t3_b3_data", out_data, 8'h03);
        check_value("t3_b3_last", out_last, 1);
        check_value("t3_b3_rdy1", in1_rdy, 0);
        tick();
        in0_val = 0; in0_last = 0;
        #1;
        check_value("t3_sw_sel",  sel, 1);
        check_value("t3_sw_data", out_data, 8'h44);
        check_value("t3_sw_val",  out_val, 1);
        check_value("t3_sw_rdy1", in1_rdy, 1);
        check_value("t3_sw_rdy0", in0_rdy, 0);
        tick();
        in1_val = 0;
        #1;
        check_value("t3_end_val", out_val, 0);

        // ---------------- Test 4: back-pressure while granted ----------------
        do_reset();
        in1_val = 1; in1_last = 1; in1_data = 8'h5A;
        out_rdy = 0;
        tick();
        xfer_base = xfer_cnt;
        for (int i = 0; i < 4; i++) begin
            check_value("t4_stall_val",  out_val, 1);
            check_value("t4_stall_rdy1", in1_rdy, 0);
            check_value("t4_stall_data", out_data, 8'h5A);
            check_value("t4_stall_sel",  sel, 1);
            tick();
        end
        check_value("t4_no_xfer", xfer_cnt - xfer_base, 0);
        out_rdy = 1;
        #1;
        check_value("t4_go_rdy1", in1_rdy, 1);
        tick();
        in1_val = 0;
        #1;
        check_value("t4_end_val", out_val, 0);
        tick();
        tick();
        check_value("t4_one_xfer", xfer_cnt - xfer_base, 1);

        // ---------------- Test 5: async reset mid-packet ----------------
        do_reset();
        in1_val = 1; in1_last = 0; in1_data = 8'h77;
        tick();
        check_value("t5_gnt_sel", sel, 1);
        tick();
        in1_data = 8'h78;
        #1;
        check_value("t5_mid_val", out_val, 1);
        #1;
        reset = 1;
        #1;
        check_value("t5_rst_val",  out_val, 0);
        check_value("t5_rst_rdy1", in1_rdy, 0);
        check_value("t5_rst_sel",  sel, 0);
        @(negedge clk);
        reset = 0;
        in0_val = 1; in0_last = 1; in0_data = 8'h10;
        in1_val = 1; in1_last = 1; in1_data = 8'h20;
        #1;
        check_value("t5_post_bubble", out_val, 0);
        tick();
        check_value("t5_post_sel",  sel, 0);
        check_value("t5_post_data", out_data, 8'h10);
        check_value("t5_post_rdy0", in0_rdy, 1);
        check_value("t5_post_rdy1", in1_rdy, 0);
        tick();
        check_value("t5_next_sel",  sel, 1);
        check_value("t5_next_data", out_data, 8'h20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
